// File: rtl/cpu_control_unit.sv
// Control sequencer for the 8-bit CPU: fetch, decode and per-opcode micro-states,
// with every output decoded from the state register alone.
module cpu_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic [2:0] ALU_Sel,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  localparam logic [7:0] LDA_IMM = 8'h10, LDA_DIR = 8'h11, LDB_IMM = 8'h12, LDB_DIR = 8'h13;
  localparam logic [7:0] STA_DIR = 8'h14, STB_DIR = 8'h15;
  localparam logic [7:0] ADD_AB = 8'h20, SUB_AB = 8'h21, AND_AB = 8'h22, OR_AB = 8'h23;
  localparam logic [7:0] INCA = 8'h24, INCB = 8'h25, DECA = 8'h26, DECB = 8'h27;
  localparam logic [7:0] BRA = 8'h30, BNU = 8'h31, BND = 8'h32, BZU = 8'h33, BZD = 8'h34;
  localparam logic [7:0] BVU = 8'h35, BVD = 8'h36, BCU = 8'h37, BCD = 8'h38;

  localparam logic [1:0] BUS1_PC = 2'b00, BUS1_A = 2'b01, BUS1_B = 2'b10;
  localparam logic [1:0] BUS2_ALU = 2'b00, BUS2_BUS1 = 2'b01, BUS2_MEM = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_INC = 3'b100, ALU_DEC = 3'b101;

  typedef enum logic [5:0] {
    FETCH_0, FETCH_1, FETCH_2, DECODE_3,
    LDA_IMM_4, LDA_IMM_5, LDA_IMM_6,
    LDB_IMM_4, LDB_IMM_5, LDB_IMM_6,
    LDA_DIR_4, LDA_DIR_5, LDA_DIR_6, LDA_DIR_7, LDA_DIR_8,
    LDB_DIR_4, LDB_DIR_5, LDB_DIR_6, LDB_DIR_7, LDB_DIR_8,
    STA_DIR_4, STA_DIR_5, STA_DIR_6, STA_DIR_7,
    STB_DIR_4, STB_DIR_5, STB_DIR_6, STB_DIR_7,
    ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4,
    INCA_4, INCB_4, DECA_4, DECB_4,
    BR_4, BR_5, BR_6, BR_SKIP_4
  } state_t;

  state_t state, next_state;
  logic   branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_0;
    else        state <= next_state;
  end

  // Flags are {N,Z,V,C}; only meaningful while the opcode is a branch.
  always_comb begin
    branch_taken = 1'b0;
    case (IR)
      BRA:     branch_taken = 1'b1;
      BNU:     branch_taken = CCR_Result[3];
      BND:     branch_taken = !CCR_Result[3];
      BZU:     branch_taken = CCR_Result[2];
      BZD:     branch_taken = !CCR_Result[2];
      BVU:     branch_taken = CCR_Result[1];
      BVD:     branch_taken = !CCR_Result[1];
      BCU:     branch_taken = CCR_Result[0];
      BCD:     branch_taken = !CCR_Result[0];
      default: branch_taken = 1'b0;
    endcase
  end

  // Outputs are gated by reset so nothing loads or writes while reset is held.
  always_comb begin
    next_state = FETCH_0;
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    A_Load     = 1'b0;
    B_Load     = 1'b0;
    ALU_Sel    = ALU_ADD;
    CCR_Load   = 1'b0;
    Bus1_Sel   = BUS1_PC;
    Bus2_Sel   = BUS2_ALU;
    write      = 1'b0;
    if (reset) begin
      case (state)
        FETCH_0: begin
          Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = FETCH_1;
        end
        FETCH_1: begin
          PC_Inc = 1'b1; next_state = FETCH_2;
        end
        FETCH_2: begin
          Bus2_Sel = BUS2_MEM; IR_Load = 1'b1; next_state = DECODE_3;
        end
        DECODE_3: begin
          case (IR)
            LDA_IMM: next_state = LDA_IMM_4;
            LDB_IMM: next_state = LDB_IMM_4;
            LDA_DIR: next_state = LDA_DIR_4;
            LDB_DIR: next_state = LDB_DIR_4;
            STA_DIR: next_state = STA_DIR_4;
            STB_DIR: next_state = STB_DIR_4;
            ADD_AB:  next_state = ADD_AB_4;
            SUB_AB:  next_state = SUB_AB_4;
            AND_AB:  next_state = AND_AB_4;
            OR_AB:   next_state = OR_AB_4;
            INCA:    next_state = INCA_4;
            INCB:    next_state = INCB_4;
            DECA:    next_state = DECA_4;
            DECB:    next_state = DECB_4;
            BRA, BNU, BND, BZU, BZD, BVU, BVD, BCU, BCD:
              next_state = branch_taken ? BR_4 : BR_SKIP_4;
            default: next_state = FETCH_0;
          endcase
        end
        LDA_IMM_4: begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = LDA_IMM_5; end
        LDA_IMM_5: begin PC_Inc = 1'b1; next_state = LDA_IMM_6; end
        LDA_IMM_6: begin Bus2_Sel = BUS2_MEM; A_Load = 1'b1; end
        LDB_IMM_4: begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = LDB_IMM_5; end
        LDB_IMM_5: begin PC_Inc = 1'b1; next_state = LDB_IMM_6; end
        LDB_IMM_6: begin Bus2_Sel = BUS2_MEM; B_Load = 1'b1; end
        LDA_DIR_4: begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = LDA_DIR_5; end
        LDA_DIR_5: begin PC_Inc = 1'b1; next_state = LDA_DIR_6; end
        LDA_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = LDA_DIR_7; end
        LDA_DIR_7: next_state = LDA_DIR_8;
        LDA_DIR_8: begin Bus2_Sel = BUS2_MEM; A_Load = 1'b1; end
        LDB_DIR_4: begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = LDB_DIR_5; end
        LDB_DIR_5: begin PC_Inc = 1'b1; next_state = LDB_DIR_6; end
        LDB_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = LDB_DIR_7; end
        LDB_DIR_7: next_state = LDB_DIR_8;
        LDB_DIR_8: begin Bus2_Sel = BUS2_MEM; B_Load = 1'b1; end
        STA_DIR_4: begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = STA_DIR_5; end
        STA_DIR_5: begin PC_Inc = 1'b1; next_state = STA_DIR_6; end
        STA_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = STA_DIR_7; end
        STA_DIR_7: begin Bus1_Sel = BUS1_A; write = 1'b1; end
        STB_DIR_4: begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = STB_DIR_5; end
        STB_DIR_5: begin PC_Inc = 1'b1; next_state = STB_DIR_6; end
        STB_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = STB_DIR_7; end
        STB_DIR_7: begin Bus1_Sel = BUS1_B; write = 1'b1; end
        ADD_AB_4: begin ALU_Sel = ALU_ADD; Bus1_Sel = BUS1_B; A_Load = 1'b1; CCR_Load = 1'b1; end
        SUB_AB_4: begin ALU_Sel = ALU_SUB; Bus1_Sel = BUS1_B; A_Load = 1'b1; CCR_Load = 1'b1; end
        AND_AB_4: begin ALU_Sel = ALU_AND; Bus1_Sel = BUS1_B; A_Load = 1'b1; CCR_Load = 1'b1; end
        OR_AB_4:  begin ALU_Sel = ALU_OR;  Bus1_Sel = BUS1_B; A_Load = 1'b1; CCR_Load = 1'b1; end
        INCA_4:   begin ALU_Sel = ALU_INC; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
        INCB_4:   begin ALU_Sel = ALU_INC; Bus1_Sel = BUS1_B; B_Load = 1'b1; CCR_Load = 1'b1; end
        DECA_4:   begin ALU_Sel = ALU_DEC; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
        DECB_4:   begin ALU_Sel = ALU_DEC; Bus1_Sel = BUS1_B; B_Load = 1'b1; CCR_Load = 1'b1; end
        BR_4:      begin Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1; next_state = BR_5; end
        BR_5:      next_state = BR_6;
        BR_6:      begin Bus2_Sel = BUS2_MEM; PC_Load = 1'b1; end
        BR_SKIP_4: PC_Inc = 1'b1;
        default:   next_state = FETCH_0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: random opcode/flag streams checked cycle by cycle
// against micro-op sequences built from the instruction set description.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [14:0] ctrlWord;

  int checkCount = 0;
  int errorCount = 0;

  logic [14:0] expQ[$];

  // Control word fields, packed in the same order as ctrlWord.
  localparam logic [14:0] W      = 15'h0001;
  localparam logic [14:0] B2_B1  = 15'h0002;
  localparam logic [14:0] B2_MEM = 15'h0004;
  localparam logic [14:0] B1_A   = 15'h0008;
  localparam logic [14:0] B1_B   = 15'h0010;
  localparam logic [14:0] CCRL   = 15'h0020;
  localparam logic [14:0] BL     = 15'h0200;
  localparam logic [14:0] AL     = 15'h0400;
  localparam logic [14:0] PCI    = 15'h0800;
  localparam logic [14:0] PCL    = 15'h1000;
  localparam logic [14:0] MARL   = 15'h2000;
  localparam logic [14:0] IRL    = 15'h4000;

  logic [7:0] definedOps [23] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                                  8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                                  8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
  );

  assign ctrlWord = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
                     CCR_Load, Bus1_Sel, Bus2_Sel, write};

  always #5 clk = ~clk;

  function automatic logic [14:0] aluSel(input int n);
    return 15'(n) << 6;
  endfunction

  // Fills expQ with one control word per clock for the whole instruction.
  task automatic buildExpected(input logic [7:0] op, input logic [3:0] ccr);
    int idx;
    logic wantSet, taken;
    expQ.delete();
    expQ.push_back(MARL | B2_B1);
    expQ.push_back(PCI);
    expQ.push_back(IRL | B2_MEM);
    expQ.push_back(15'h0);
    if (op == 8'h10 || op == 8'h12) begin
      expQ.push_back(MARL | B2_B1);
      expQ.push_back(PCI);
      expQ.push_back(((op == 8'h10) ? AL : BL) | B2_MEM);
    end else if (op == 8'h11 || op == 8'h13) begin
      expQ.push_back(MARL | B2_B1);
      expQ.push_back(PCI);
      expQ.push_back(MARL | B2_MEM);
      expQ.push_back(15'h0);
      expQ.push_back(((op == 8'h11) ? AL : BL) | B2_MEM);
    end else if (op == 8'h14 || op == 8'h15) begin
      expQ.push_back(MARL | B2_B1);
      expQ.push_back(PCI);
      expQ.push_back(MARL | B2_MEM);
      expQ.push_back(W | ((op == 8'h14) ? B1_A : B1_B));
    end else if (op >= 8'h20 && op <= 8'h23) begin
      expQ.push_back(B1_B | AL | CCRL | aluSel(int'(op) - 32));
    end else if (op >= 8'h24 && op <= 8'h27) begin
      expQ.push_back(((op[0] == 1'b0) ? (B1_A | AL) : (B1_B | BL)) | CCRL |
                     aluSel((op >= 8'h26) ? 5 : 4));
    end else if (op >= 8'h30 && op <= 8'h38) begin
      if (op == 8'h30) taken = 1'b1;
      else begin
        idx     = (int'(op) - 8'h31) / 2;
        wantSet = ((int'(op) - 8'h31) % 2) == 0;
        taken   = (ccr[3 - idx] == wantSet);
      end
      if (taken) begin
        expQ.push_back(MARL | B2_B1);
        expQ.push_back(15'h0);
        expQ.push_back(PCL | B2_MEM);
      end else begin
        expQ.push_back(PCI);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] observed, input logic [14:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %04h expected %04h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Runs one instruction from FETCH_0; abortAt>=0 pulls reset right after that micro-step.
  task automatic applyStimulus(input logic [7:0] op, input logic [3:0] ccr, input int abortAt);
    string tag;
    IR         = op;
    CCR_Result = ccr;
    buildExpected(op, ccr);
    tag = $sformatf("op%02h", op);
    for (int i = 0; expQ.size() > 0; i++) begin
      #1 checkOutput(tag, ctrlWord, expQ.pop_front());
      if (i == abortAt) begin
        expQ.delete();
        reset = 1'b0;
        #1 checkOutput("abort", ctrlWord, 15'h0);
        @(negedge clk);
        #1 checkOutput("abort_hold", ctrlWord, 15'h0);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] op;
    reset      = 1'b0;
    IR         = 8'($urandom);
    CCR_Result = 4'($urandom);
    repeat (3) begin
      @(negedge clk);
      #1 checkOutput("rst", ctrlWord, 15'h0);
    end
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(8'h10, 4'h0, -1);
    applyStimulus(8'h14, 4'h0, -1);
    applyStimulus(8'h20, 4'h0, -1);
    applyStimulus(8'h33, 4'b0100, -1);
    applyStimulus(8'h33, 4'b0000, -1);
    applyStimulus(8'hFF, 4'h0, -1);
    applyStimulus(8'h11, 4'h0, 6);
    applyStimulus(8'h10, 4'h0, -1);

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = definedOps[$urandom_range(0, 22)];
      applyStimulus(op, 4'($urandom), ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Moore-style finite state machine that sequences the 8-bit CPU datapath: program counter (PC), memory address register (MAR), instruction register (IR), registers A and B, the ALU and the condition-code register (CCR). It also drives the synchronous ROM/RW memory. It fetches each opcode, decodes it, and steps through the per-instruction micro-states. It accounts for the one-cycle read latency of the synchronous memory, whose data_out is valid one clock edge after the address is presented.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR  in  8  current instruction register contents (opcode).
- CCR_Result  in  4  condition flags {N,Z,V,C}, bit 3 = N.
- IR_Load  out  1  load IR from Bus2.
- MAR_Load  out  1  load MAR from Bus2.
- PC_Load  out  1  load PC from Bus2.
- PC_Inc  out  1  increment PC.
- A_Load  out  1  load A from Bus2.
- B_Load  out  1  load B from Bus2.
- ALU_Sel  out  3  ALU operation select:
  - 000 ADD (A+Bus1)
  - 001 SUB (A−Bus1)
  - 010 AND
  - 011 OR
  - 100 INC (Bus1+1)
  - 101 DEC (Bus1−1)
- CCR_Load  out  1  load CCR from the ALU flags.
- Bus1_Sel  out  2  Bus1 source: 00 PC, 01 A, 10 B.
- Bus2_Sel  out  2  Bus2 source: 00 ALU, 01 Bus1, 10 memory data_out.
- write  out  1  memory write strobe (address = MAR, data = Bus1).

## Operation
- Opcodes:
  - 10 LDA_IMM, 11 LDA_DIR, 12 LDB_IMM, 13 LDB_DIR, 14 STA_DIR, 15 STB_DIR
  - 20 ADD_AB, 21 SUB_AB, 22 AND_AB, 23 OR_AB, 24 INCA, 25 INCB, 26 DECA, 27 DECB
  - 30 BRA, 31 BNU (N=1), 32 BND (N=0), 33 BZU (Z=1), 34 BZD (Z=0), 35 BVU (V=1), 36 BVD (V=0), 37 BCU (C=1), 38 BCD (C=0)
- Output defaults: every output is 0 unless the active state asserts it. Bus selects default to 00.
- Fetch sequence:
  - FETCH_0: Bus1=PC, Bus2=Bus1, MAR_Load.
  - FETCH_1: PC_Inc (memory latency cycle).
  - FETCH_2: Bus2=mem, IR_Load.
  - DECODE_3: no outputs asserted. Next state is selected from IR, and from CCR_Result for conditional branches.
- Immediate loads (LDA_IMM/LDB_IMM):
  - 4: Bus1=PC, Bus2=Bus1, MAR_Load.
  - 5: PC_Inc.
  - 6: Bus2=mem, A_Load (or B_Load).
  - Then FETCH_0.
- Direct loads (LDA_DIR/LDB_DIR):
  - 4: MAR←PC.
  - 5: PC_Inc.
  - 6: Bus2=mem, MAR_Load.
  - 7: wait.
  - 8: Bus2=mem, A_Load (or B_Load).
  - Then FETCH_0.
- Direct stores (STA_DIR/STB_DIR):
  - 4: MAR←PC.
  - 5: PC_Inc.
  - 6: Bus2=mem, MAR_Load.
  - 7: Bus1=A (or B), write.
  - Then FETCH_0.
- ALU ops take one state (4), then FETCH_0. Every ALU op asserts Bus2=ALU and CCR_Load.
  - ADD/SUB/AND/OR: Bus1=B, A_Load, ALU_Sel per op.
  - INCA/DECA: Bus1=A, A_Load.
  - INCB/DECB: Bus1=B, B_Load.
- Branch, taken (BRA, or conditional with condition true at DECODE_3):
  - 4: MAR←PC.
  - 5: wait.
  - 6: Bus2=mem, PC_Load.
  - Then FETCH_0.
- Branch, not taken: one state asserting PC_Inc (skips the operand byte), then FETCH_0.
- Undefined opcode: DECODE_3 returns directly to FETCH_0. The PC has already advanced one byte, so the opcode executes as a NOP.

## Timing
- Cycles per instruction, including fetch and decode:
  - ALU op: 5
  - LD immediate: 7
  - LD direct: 9
  - ST direct: 8
  - Branch taken: 7
  - Branch not taken: 5
  - Undefined opcode: 4
- All outputs are combinational decodes of the state register only. There are no Mealy paths and no glitch-relevant inputs.
- CCR_Result is sampled only at the DECODE_3 edge. A CCR_Load in the preceding instruction's final state is visible by then.
- Reset:
  - While reset=0, the state is held at FETCH_0 and all outputs are forced to 0.
  - On release, FETCH_0 outputs appear immediately; the first rising edge enters FETCH_1.
- Reset asserted mid-instruction aborts it at once. No write or load may be asserted during or after assertion until FETCH_0 is re-entered.
- write is high for exactly one cycle per store. It is never high in any other state.

## Test plan
- Reset low then release, IR=xx → all outputs 0 during reset. After release: FETCH_0 (MAR_Load=1, Bus2_Sel=01), then FETCH_1 (PC_Inc=1), then FETCH_2 (IR_Load=1, Bus2_Sel=10).
- IR=10 → after DECODE_3: MAR_Load, PC_Inc, then A_Load with Bus2_Sel=10. Back at FETCH_0 on cycle 8; total 7 cycles.
- IR=14 → write=1 with Bus1_Sel=01 in state 7 only, for exactly 1 cycle. Instruction totals 8 cycles.
- IR=20 → one cycle with ALU_Sel=000, Bus1_Sel=10, Bus2_Sel=00, A_Load=1, CCR_Load=1.
- Branch outcomes:
  - IR=33, CCR_Result=4'b0100 → taken: PC_Load=1 with Bus2_Sel=10 in state 6.
  - IR=33, CCR_Result=4'b0000 → not taken: single PC_Inc state, then FETCH_0.
- IR=FF → DECODE_3 goes straight to FETCH_0. Separately, assert reset during LDA_DIR state 6 → outputs 0 immediately, and the state is FETCH_0 on release.
